// File: rtl/semaforo_monitor.sv
// rtl/semaforo_monitor.sv - passive checker for traffic-light lamp outputs
//
// Ports:
//   clk_50MHz  system clock
//   rst        synchronous reset, active-high
//   tick_1s    one-clock enable pulse per second
//   rojo, amarillo, verde  lamp inputs (already synchronous)
//   clr_err    clears sticky error flags (a same-clock set wins)
//   fase       decoded phase: 0 none/invalid, 1 rojo, 2 verde, 3 amarillo
//   dur_s      ticks elapsed in current phase (saturating)
//   phase_done one-clock pulse when a phase ends
//   last_dur   length of the phase that just ended
//   err_combo, err_seq, err_time  sticky error flags
//   ciclos     count of legal AMARILLO->ROJO transitions (wraps)
module semaforo_monitor #(
   parameter int T_ROJO     = 5,
   parameter int T_VERDE    = 4,
   parameter int T_AMARILLO = 2,
   parameter int TOL        = 0,
   parameter int CNT_W      = 8
) (
   input  logic             clk_50MHz,
   input  logic             rst,
   input  logic             tick_1s,
   input  logic             rojo,
   input  logic             amarillo,
   input  logic             verde,
   input  logic             clr_err,
   output logic [1:0]       fase,
   output logic [CNT_W-1:0] dur_s,
   output logic             phase_done,
   output logic [CNT_W-1:0] last_dur,
   output logic             err_combo,
   output logic             err_seq,
   output logic             err_time,
   output logic [15:0]      ciclos
);

   typedef enum logic [2:0] {
      S_IDLE, S_ROJO, S_VERDE, S_AMARILLO, S_FALLO
   } state_t;

   state_t           state_q, state_d;
   state_t           obs, succ;
   logic [1:0]       n_lit;
   logic             multi, dark;
   logic [CNT_W-1:0] dur_q, dur_d, last_q, last_d, nom;
   logic [CNT_W:0]   abs_diff;
   logic             done_d;
   logic             checked_q, checked_d;
   logic             set_combo, set_seq, set_time;
   logic [15:0]      ciclos_q, ciclos_d;
   logic [1:0]       fase_d;

   assign n_lit = {1'b0, rojo} + {1'b0, amarillo} + {1'b0, verde};
   assign multi = (n_lit >= 2'd2);
   assign dark  = (n_lit == 2'd0);

   // Observed phase; only meaningful when exactly one lamp is lit.
   always_comb begin
      obs = S_AMARILLO;
      if (rojo)
         obs = S_ROJO;
      else if (verde)
         obs = S_VERDE;
   end

   // Legal successor and nominal length of the current phase.
   always_comb begin
      succ = S_IDLE;
      nom  = '0;
      case (state_q)
         S_ROJO:     begin succ = S_VERDE;    nom = CNT_W'(T_ROJO);     end
         S_VERDE:    begin succ = S_AMARILLO; nom = CNT_W'(T_VERDE);    end
         S_AMARILLO: begin succ = S_ROJO;     nom = CNT_W'(T_AMARILLO); end
         default:    begin succ = S_IDLE;     nom = '0;                 end
      endcase
   end

   assign abs_diff = (dur_q >= nom) ? {1'b0, dur_q - nom} : {1'b0, nom - dur_q};

   always_comb begin
      state_d   = state_q;
      dur_d     = dur_q;
      last_d    = last_q;
      done_d    = 1'b0;
      checked_d = checked_q;
      set_combo = 1'b0;
      set_seq   = 1'b0;
      set_time  = 1'b0;
      ciclos_d  = ciclos_q;

      if (multi) begin
         set_combo = 1'b1;
         state_d   = S_FALLO;
         dur_d     = '0;
         checked_d = 1'b0;
      end else if (dark) begin
         state_d   = S_IDLE;
         dur_d     = '0;
         checked_d = 1'b0;
      end else begin
         case (state_q)
            S_ROJO, S_VERDE, S_AMARILLO: begin
               if (obs == state_q) begin
                  if (tick_1s && (dur_q != {CNT_W{1'b1}}))
                     dur_d = dur_q + CNT_W'(1);
               end else begin
                  // Phase change: a tick in this cycle is deliberately dropped.
                  done_d  = 1'b1;
                  last_d  = dur_q;
                  dur_d   = '0;
                  state_d = obs;
                  if (checked_q && (abs_diff > (CNT_W+1)'(TOL)))
                     set_time = 1'b1;
                  if (obs == succ) begin
                     checked_d = 1'b1;
                     if (state_q == S_AMARILLO)
                        ciclos_d = ciclos_q + 16'd1;
                  end else begin
                     set_seq   = 1'b1;
                     checked_d = 1'b0;
                  end
               end
            end
            default: begin
               // From IDLE or FALLO the first phase is partial: never checked.
               state_d   = obs;
               dur_d     = '0;
               checked_d = 1'b0;
            end
         endcase
      end

      case (state_d)
         S_ROJO:     fase_d = 2'd1;
         S_VERDE:    fase_d = 2'd2;
         S_AMARILLO: fase_d = 2'd3;
         default:    fase_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         state_q    <= S_IDLE;
         dur_q      <= '0;
         last_q     <= '0;
         phase_done <= 1'b0;
         checked_q  <= 1'b0;
         err_combo  <= 1'b0;
         err_seq    <= 1'b0;
         err_time   <= 1'b0;
         ciclos_q   <= '0;
         fase       <= 2'd0;
      end else begin
         state_q    <= state_d;
         dur_q      <= dur_d;
         last_q     <= last_d;
         phase_done <= done_d;
         checked_q  <= checked_d;
         err_combo  <= set_combo | (err_combo & ~clr_err);
         err_seq    <= set_seq   | (err_seq   & ~clr_err);
         err_time   <= set_time  | (err_time  & ~clr_err);
         ciclos_q   <= ciclos_d;
         fase       <= fase_d;
      end
   end

   assign dur_s    = dur_q;
   assign last_dur = last_q;
   assign ciclos   = ciclos_q;

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
- Passive checker on the lamp outputs (rojo/amarillo/verde) of the traffic-light controller. It is the reading end of that interface.
- Decodes the current phase and measures each phase length in 1 s ticks.
- Checks lamp combinations, phase order (ROJO->VERDE->AMARILLO->ROJO) and phase durations. Raises sticky error flags and counts completed cycles.
- Sits beside the controller top in the same 50 MHz domain, driven by the same 1 s enable pulse. It is used in hardware self-test and in simulation.

Parameters:
- T_ROJO, 5, nominal red duration in ticks
- T_VERDE, 4, nominal green duration in ticks
- T_AMARILLO, 2, nominal yellow duration in ticks
- TOL, 0, allowed ± deviation in ticks
- CNT_W, 8, width of duration counters

Ports:
- clk_50MHz  in  1  single system clock
- rst  in  1  synchronous reset, active-high
- tick_1s  in  1  one-clock enable pulse, once per second
- rojo  in  1  red lamp
- amarillo  in  1  yellow lamp
- verde  in  1  green lamp
- clr_err  in  1  synchronous clear of sticky error flags
- fase  out  2  decoded phase: 0 = none/invalid, 1 = rojo, 2 = verde, 3 = amarillo
- dur_s  out  CNT_W  ticks elapsed in current phase
- phase_done  out  1  one-clock pulse when a phase ends
- last_dur  out  CNT_W  length of the phase that just ended; valid with phase_done, held otherwise
- err_combo  out  1  sticky: more than one lamp lit
- err_seq  out  1  sticky: illegal phase order
- err_time  out  1  sticky: phase length outside nominal ±TOL
- ciclos  out  16  count of legal AMARILLO->ROJO transitions

Behaviour:
- Reset:
  - All interface signals are synchronous to clk_50MHz. The lamps are sampled directly, with no synchronizer.
  - On rst, every output is 0 and the FSM goes to IDLE.
  - rst has priority over clr_err and over every other event.
  - rst asserted mid-phase discards the partial count.
- Lamp decode, each clock:
  - Exactly one lamp lit gives a valid phase.
  - Zero lamps gives DARK.
  - Two or more lamps gives MULTI.
- FSM states: IDLE, ROJO, VERDE, AMARILLO, FALLO.
  - IDLE: fase = 0. On a valid phase, enter that state with dur_s = 0. There is no seq or time check (first phase is partial), and phase_done does not pulse.
  - ROJO / VERDE / AMARILLO, decoded value equal to current state: if tick_1s, then dur_s <= dur_s + 1, saturating at 2^CNT_W−1.
  - Decoded value is a different valid phase (phase change):
    - phase_done = 1 for one clock; last_dur <= dur_s; dur_s <= 0.
    - A tick_1s in the change cycle is ignored.
    - If the previous phase was entered from a legal transition, compare last_dur with its nominal value. |last_dur − T_x| > TOL sets err_time.
    - If the new phase is not the legal successor, set err_seq. The FSM still moves to the observed phase. That phase is marked unchecked for timing, like entry from IDLE.
    - A legal AMARILLO->ROJO transition increments ciclos. ciclos wraps from 0xFFFF to 0.
  - Decoded DARK: go to IDLE, dur_s <= 0, no error, no phase_done.
  - Decoded MULTI, from any state: set err_combo, go to FALLO, dur_s <= 0, fase = 0.
  - FALLO: stay while MULTI.
    - DARK -> IDLE.
    - Valid phase -> that phase, unchecked (no seq or time check).
- Sticky flags:
  - err_combo, err_seq and err_time are set only by the events above.
  - clr_err clears all three.
  - If clr_err and a set event occur in the same clock, set wins.
- Output timing: all outputs are registered. fase, dur_s and phase_done reflect a lamp or tick_1s change one clock after the input change.
- Combinational path: none from inputs to outputs.
- Implementation size: roughly 150–250 lines of RTL.

Test Plan:
1. Reset, then legal sequence R5/V4/A2 ticks, repeated 3 cycles. Required: ciclos = 2 (the first red is unchecked, and the first A->R counts). phase_done pulses with last_dur 5, 4, 2 in turn. All error flags stay 0.
2. Green held 6 ticks, TOL = 0, from a checked entry. Required: err_time = 1 on the clock after the V->A change, and last_dur = 6. With TOL = 2 the same stimulus gives no error.
3. Illegal order R->A. Required: err_seq = 1, fase = 3, ciclos unchanged. The following A->R is legal and increments ciclos. A short yellow on that unchecked phase must not set err_time.
4. rojo and verde both high for 1 clock mid-red. Required: err_combo = 1, fase = 0. Returning to verde only gives fase = 2 with no err_seq.
5. clr_err pulsed alone clears all flags. clr_err in the same clock as a MULTI event leaves err_combo = 1. rst mid-green gives all outputs 0 and IDLE.
6. Force ciclos to 0xFFFF with 65536 short cycles (or a parameter override), then one more A->R. Required: ciclos = 0. Hold a phase for 300 ticks with CNT_W = 8. Required: dur_s saturates at 255. A tick in the phase-change cycle is not counted.
